// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer slice.
// Optional perf counters: FETCH_PERF_CNT_EN.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    REDIRECT,
    HALTED
  } fetch_seq_state_t;

  localparam word_t FETCH_PC_RESET = 32'h0000_0000;

  function automatic word_t align(word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: redirect/I-cache inputs
// and fetch-stage outputs.
interface fetch_sequencer_if;
  import cpu_types_pkg::*;

  logic  ihit;
  logic  hz_stall;
  logic  jmp_req;
  word_t jmp_target;
  logic  br_req;
  word_t br_target;
  logic  halt;
  logic  imemREN;
  word_t imemaddr;
  logic  fs_stall;
  logic  fs_ihit;
  logic  fs_pc_control;
  word_t fs_nxt_pc;
  logic  halted;

  modport master (
    input  ihit, hz_stall,
    input  jmp_req, jmp_target,
    input  br_req, br_target,
    input  halt,
    output imemREN, imemaddr,
    output fs_stall, fs_ihit,
    output fs_pc_control, fs_nxt_pc,
    output halted
  );

  modport slave (
    output ihit, hz_stall,
    output jmp_req, jmp_target,
    output br_req, br_target,
    output halt,
    input  imemREN, imemaddr,
    input  fs_stall, fs_ihit,
    input  fs_pc_control, fs_nxt_pc,
    input  halted
  );

endinterface

// File: rtl/fetch_sequencer_perf.sv
// Saturating 32-bit event counter used for
// fetch perf stats (FETCH_PERF_CNT_EN).
module fetch_perf_counter
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  en,
  output word_t cnt
);

  always_ff @(posedge CLK) begin
    if (!nRST)
      cnt <= '0;
    else if (en && cnt != '1)
      cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch sequencer (IDLE/FETCH/REDIRECT/HALTED).
// FETCH_PERF_CNT_EN adds fetch and stall counters.
module fetch_sequencer
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = FETCH_PC_RESET,
  parameter int    PC_STEP  = 4
) (
  input logic CLK,
  input logic nRST,
  fetch_sequencer_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output word_t perf_fetch_cnt,
  output word_t perf_stall_cnt
`endif
);

  fetch_seq_state_t state, state_n;

  word_t pc, pc_n;
  word_t pend_pc, pend_n;
  word_t target, rtarget;
  word_t nxt;
  logic  redirect;
  logic  ren, fih, pcc, hltd;
  logic  stall;

  always_comb begin
    redirect = bus.br_req | bus.jmp_req;
    target   = pc + word_t'(PC_STEP);
    rtarget  = pend_pc;
    if (bus.br_req) begin
      target  = align(bus.br_target);
      rtarget = target;
    end else if (bus.jmp_req) begin
      target  = align(bus.jmp_target);
      rtarget = target;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend_pc;
    ren     = 1'b0;
    fih     = 1'b0;
    pcc     = 1'b0;
    nxt     = pc;
    hltd    = 1'b0;
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        ren = 1'b1;
        fih = bus.ihit & ~bus.hz_stall;
        pcc = redirect;
        nxt = target;
        if (bus.halt) begin
          state_n = HALTED;
        end else if (bus.ihit) begin
          if (!bus.hz_stall || redirect)
            pc_n = target;
        end else if (redirect) begin
          // in-flight fetch is stale; park target
          pend_n  = target;
          state_n = REDIRECT;
        end
      end
      REDIRECT: begin
        ren    = 1'b1;
        pcc    = 1'b1;
        nxt    = rtarget;
        pend_n = rtarget;
        if (bus.halt) begin
          state_n = HALTED;
        end else if (bus.ihit) begin
          pc_n    = rtarget;
          state_n = FETCH;
        end
      end
      HALTED: hltd = 1'b1;
      default: state_n = IDLE;
    endcase
    // reset cycle: ignore any ihit, present reset values
    if (!nRST) begin
      ren  = 1'b0;
      fih  = 1'b0;
      pcc  = 1'b0;
      nxt  = PC_RESET;
      hltd = 1'b0;
    end
  end

  assign stall = bus.hz_stall | ~fih;

  assign bus.imemREN       = ren;
  assign bus.imemaddr      = pc;
  assign bus.fs_stall      = stall;
  assign bus.fs_ihit       = fih;
  assign bus.fs_pc_control = pcc;
  assign bus.fs_nxt_pc     = nxt;
  assign bus.halted        = hltd;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      pc      <= PC_RESET;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_ev;

  assign stall_ev = stall &
    (state == FETCH || state == REDIRECT);

  fetch_perf_counter u_fetch_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (fih),
    .cnt  (perf_fetch_cnt)
  );

  fetch_perf_counter u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (stall_ev),
    .cnt  (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table
// plus wrap/halt and reset-in-redirect sequences.
module tb_fetch_sequencer;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;

  fetch_sequencer_if bus ();

`ifdef FETCH_PERF_CNT_EN
  word_t perf_fetch_cnt;
  word_t perf_stall_cnt;
`endif

  fetch_sequencer dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic  nrst;
    logic  ihit;
    logic  hz;
    logic  jmp;
    word_t jt;
    logic  br;
    word_t bt;
    logic  halt;
    word_t addr;
    logic  ren;
    logic  stall;
    logic  fih;
    logic  pcc;
    word_t nxt;
    logic  hltd;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  int n_chk;
  int n_fail;

  function automatic vec_t mk(
    logic nrst, logic ihit, logic hz,
    logic jmp, word_t jt,
    logic br, word_t bt, logic halt,
    word_t addr, logic ren, logic stall,
    logic fih, logic pcc, word_t nxt,
    logic hltd);
    vec_t v;
    v.nrst = nrst; v.ihit = ihit; v.hz = hz;
    v.jmp = jmp; v.jt = jt;
    v.br = br; v.bt = bt; v.halt = halt;
    v.addr = addr; v.ren = ren;
    v.stall = stall; v.fih = fih;
    v.pcc = pcc; v.nxt = nxt; v.hltd = hltd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input word_t act,
                     input word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drv(input logic ih, input logic hz,
                     input logic jm, input word_t jt,
                     input logic b, input word_t bt,
                     input logic h);
    bus.ihit       = ih;
    bus.hz_stall   = hz;
    bus.jmp_req    = jm;
    bus.jmp_target = jt;
    bus.br_req     = b;
    bus.br_target  = bt;
    bus.halt       = h;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d.addr", i),
        bus.imemaddr, v.addr);
    chk($sformatf("v%0d.ren", i),
        word_t'(bus.imemREN), word_t'(v.ren));
    chk($sformatf("v%0d.stall", i),
        word_t'(bus.fs_stall), word_t'(v.stall));
    chk($sformatf("v%0d.ihit", i),
        word_t'(bus.fs_ihit), word_t'(v.fih));
    chk($sformatf("v%0d.pcctl", i),
        word_t'(bus.fs_pc_control), word_t'(v.pcc));
    chk($sformatf("v%0d.nxt", i),
        bus.fs_nxt_pc, v.nxt);
    chk($sformatf("v%0d.halted", i),
        word_t'(bus.halted), word_t'(v.hltd));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // nrst ih hz jm jt br bt halt | addr ren stl fih pcc nxt hlt
    tbl[0]  = mk(0,0,0,0,0,0,0,0, 32'h0,  0,1,0,0, 32'h0,   0);
    tbl[1]  = mk(1,1,0,0,0,0,0,0, 32'h0,  0,1,0,0, 32'h0,   0);
    tbl[2]  = mk(1,1,0,0,0,0,0,0, 32'h0,  1,0,1,0, 32'h4,   0);
    tbl[3]  = mk(1,1,0,0,0,0,0,0, 32'h4,  1,0,1,0, 32'h8,   0);
    tbl[4]  = mk(1,1,1,0,0,0,0,0, 32'h8,  1,1,0,0, 32'hC,   0);
    tbl[5]  = mk(1,1,1,0,0,0,0,0, 32'h8,  1,1,0,0, 32'hC,   0);
    tbl[6]  = mk(1,1,1,0,0,0,0,0, 32'h8,  1,1,0,0, 32'hC,   0);
    tbl[7]  = mk(1,1,0,0,0,0,0,0, 32'h8,  1,0,1,0, 32'hC,   0);
    tbl[8]  = mk(1,0,0,0,0,0,0,0, 32'hC,  1,1,0,0, 32'h10,  0);
    tbl[9]  = mk(1,0,0,0,0,1,32'h103,0,
                 32'hC, 1,1,0,1, 32'h100, 0);
    tbl[10] = mk(1,0,0,0,0,0,0,0, 32'hC,  1,1,0,1, 32'h100, 0);
    tbl[11] = mk(1,1,0,0,0,0,0,0, 32'hC,  1,1,0,1, 32'h100, 0);
    tbl[12] = mk(1,1,0,1,32'h300,1,32'h200,0,
                 32'h100, 1,0,1,1, 32'h200, 0);
    tbl[13] = mk(1,1,0,1,32'h302,0,0,0,
                 32'h200, 1,0,1,1, 32'h300, 0);
    tbl[14] = mk(1,1,1,1,32'h40,0,0,0,
                 32'h300, 1,1,0,1, 32'h40,  0);
    tbl[15] = mk(1,0,0,1,32'h80,0,0,0,
                 32'h40,  1,1,0,1, 32'h80,  0);
    tbl[16] = mk(1,0,0,0,0,1,32'h90,0,
                 32'h40,  1,1,0,1, 32'h90,  0);
    tbl[17] = mk(1,1,0,0,0,0,0,0, 32'h40, 1,1,0,1, 32'h90,  0);

    nRST = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      nRST = tbl[i].nrst;
      drv(tbl[i].ihit, tbl[i].hz, tbl[i].jmp,
          tbl[i].jt, tbl[i].br, tbl[i].bt,
          tbl[i].halt);
      #1;
      check_vec(i, tbl[i]);
    end

    // pc now 0x90 in FETCH
    @(negedge CLK);
    drv(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("seq.addr90", bus.imemaddr, 32'h90);
    chk("seq.nxt94", bus.fs_nxt_pc, 32'h94);

    // jump to top of address space, then wrap
    @(negedge CLK);
    drv(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    #1;
    chk("wrap.addr94", bus.imemaddr, 32'h94);
    @(negedge CLK);
    drv(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap.addrtop", bus.imemaddr, 32'hFFFF_FFFC);
    chk("wrap.nxt0", bus.fs_nxt_pc, 32'h0);
    @(negedge CLK);
    drv(1, 0, 0, 0, 1, 32'h500, 1);
    #1;
    chk("wrap.addr0", bus.imemaddr, 32'h0);
    chk("halt.pre", word_t'(bus.halted), 32'h0);

    // halt beat br_req: parked, pc held
    @(negedge CLK);
    drv(1, 0, 0, 0, 1, 32'h500, 0);
    #1;
    chk("halt.halted", word_t'(bus.halted), 32'h1);
    chk("halt.ren", word_t'(bus.imemREN), 32'h0);
    chk("halt.addr", bus.imemaddr, 32'h0);
    @(negedge CLK);
    drv(1, 0, 1, 32'h700, 0, 0, 0);
    #1;
    chk("halt.stay", word_t'(bus.halted), 32'h1);
    chk("halt.addr2", bus.imemaddr, 32'h0);

    // reset out of HALTED, then into REDIRECT
    @(negedge CLK);
    nRST = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rst.idle_ren", word_t'(bus.imemREN), 32'h0);
    chk("rst.unhalt", word_t'(bus.halted), 32'h0);
    @(negedge CLK);
    drv(0, 0, 0, 0, 1, 32'h200, 0);
    #1;
    chk("rd.nxt", bus.fs_nxt_pc, 32'h200);
    @(negedge CLK);
    drv(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rd.pcctl", word_t'(bus.fs_pc_control), 32'h1);
    chk("rd.stall", word_t'(bus.fs_stall), 32'h1);
    chk("rd.ren", word_t'(bus.imemREN), 32'h1);

    // reset mid-REDIRECT with an outstanding ihit
    @(negedge CLK);
    nRST = 1'b0;
    drv(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rr.ihit", word_t'(bus.fs_ihit), 32'h0);
    chk("rr.ren", word_t'(bus.imemREN), 32'h0);
    chk("rr.nxt", bus.fs_nxt_pc, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rr.addr", bus.imemaddr, 32'h0);
    chk("rr.idle", word_t'(bus.imemREN), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rr.perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rr.perf_stall", perf_stall_cnt, 32'h0);
`endif
    @(negedge CLK);
    #1;
    chk("rr.fetch_ren", word_t'(bus.imemREN), 32'h1);
    chk("rr.fetch_addr", bus.imemaddr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
